// File: rtl/multi_cycle_alu_if.sv
// -----------------------------------------------------------------------------
// multi_cycle_alu_if
// Request/result bundle for multi_cycle_alu.
//
// Parameter:
//   WIDTH        operand/result width in bits
// Signals:
//   start        request strobe, accepted only while busy=0
//   op[2:0]      opcode (AND, OR, ADD, MULT, DIV, XOR, SUB, SLT)
//   in_1, in_2   operands, sampled on the accepting edge only
//   busy         high from the edge after acceptance through the done cycle
//   done         one-cycle pulse marking valid results
//   res          primary result (logic/arith result, low product, quotient)
//   hi           high product (MULT) or remainder (DIV), else 0
//   zero         result-is-zero flag, valid with done
//   div_by_zero  DIV with in_2 = 0, valid with done
// Modports:
//   master       requester side (drives start/op/operands)
//   slave        ALU side (drives status and results)
// -----------------------------------------------------------------------------
interface multi_cycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] in_1;
  logic [WIDTH-1:0] in_2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             div_by_zero;

  modport master (
    output start, op, in_1, in_2,
    input  busy, done, res, hi, zero, div_by_zero
  );

  modport slave (
    input  start, op, in_1, in_2,
    output busy, done, res, hi, zero, div_by_zero
  );
endinterface

// File: rtl/multi_cycle_alu.sv
// -----------------------------------------------------------------------------
// multi_cycle_alu
// Small ALU with single-cycle logic/arithmetic ops, a WIDTH-cycle unsigned
// shift-add multiplier and an optional WIDTH-cycle unsigned restoring divider.
//
// Parameter:
//   WIDTH   operand/result width, legal range 4..64
// Ports:
//   clk     sole clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     multi_cycle_alu_if.slave (start/op/in_1/in_2 in,
//           busy/done/res/hi/zero/div_by_zero out)
//
// Build option:
//   MULTI_CYCLE_ALU_DIV_EN  when defined, the divider and DIV state are built.
//                           When undefined, op=100 finishes in one cycle with
//                           res=0, hi=0, zero=1, div_by_zero=0.
//
// Latency (accept edge to done): 1 cycle for single-cycle ops and DIV by 0,
// WIDTH+1 cycles for MULT and DIV.
// -----------------------------------------------------------------------------
module multi_cycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  multi_cycle_alu_if.slave    bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MULT = 3'b011;
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

`ifdef MULTI_CYCLE_ALU_DIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  // work_a holds the multiplicand or divisor; {work_hi, work_lo} is the
  // shifting product or remainder/quotient pair while iterating.
  logic [WIDTH-1:0] work_a_reg;
  logic [WIDTH-1:0] work_hi_reg;
  logic [WIDTH-1:0] work_lo_reg;
  // Visible results are kept separate from the work registers so they stay
  // stable from one done pulse to the next.
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] hi_reg;
  logic             zero_reg;
  logic             dbz_reg;
  logic             busy_reg;
  logic             done_reg;

  // Single-cycle result, computed from the live request.
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] alu_hi;
  logic             alu_dbz;

  always_comb begin
    alu_res = '0;
    alu_hi  = '0;
    alu_dbz = 1'b0;
    case (bus.op)
      OP_AND: alu_res = bus.in_1 & bus.in_2;
      OP_OR:  alu_res = bus.in_1 | bus.in_2;
      OP_XOR: alu_res = bus.in_1 ^ bus.in_2;
      OP_ADD: alu_res = bus.in_1 + bus.in_2;
      OP_SUB: alu_res = bus.in_1 - bus.in_2;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.in_1) < $signed(bus.in_2))};
      OP_DIV: begin
`ifdef MULTI_CYCLE_ALU_DIV_EN
        // Only the divide-by-zero case completes here; others iterate.
        if (bus.in_2 == '0) begin
          alu_res = '1;
          alu_hi  = bus.in_1;
          alu_dbz = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  // Shift-add step: conditionally add the multiplicand into the upper half,
  // then shift the whole {carry, hi, lo} right by one. The multiplier bits
  // drain out of lo as product bits shift in from the top.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next;
  logic [WIDTH-1:0] mul_lo_next;

  always_comb begin
    mul_sum     = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, work_a_reg} : '0);
    mul_hi_next = mul_sum[WIDTH:1];
    mul_lo_next = {mul_sum[0], work_lo_reg[WIDTH-1:1]};
  end

`ifdef MULTI_CYCLE_ALU_DIV_EN
  // Restoring step: bring the next dividend bit into the partial remainder,
  // trial-subtract the divisor, keep the difference only if non-negative.
  // The remainder stays below the divisor, so WIDTH+1 bits cannot overflow.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_next;
  logic [WIDTH-1:0] div_q_next;

  always_comb begin
    div_shift    = {work_hi_reg, work_lo_reg[WIDTH-1]};
    div_diff     = div_shift - {1'b0, work_a_reg};
    div_ge       = ~div_diff[WIDTH];
    div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_q_next   = {work_lo_reg[WIDTH-2:0], div_ge};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      work_a_reg  <= '0;
      work_hi_reg <= '0;
      work_lo_reg <= '0;
      res_reg     <= '0;
      hi_reg      <= '0;
      zero_reg    <= 1'b0;
      dbz_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            busy_reg <= 1'b1;
            if (bus.op == OP_MULT) begin
              work_a_reg  <= bus.in_1;
              work_lo_reg <= bus.in_2;
              work_hi_reg <= '0;
              cnt_reg     <= '0;
              state_reg   <= MUL;
            end
`ifdef MULTI_CYCLE_ALU_DIV_EN
            else if ((bus.op == OP_DIV) && (bus.in_2 != '0)) begin
              work_a_reg  <= bus.in_2;
              work_lo_reg <= bus.in_1;
              work_hi_reg <= '0;
              cnt_reg     <= '0;
              state_reg   <= DIV;
            end
`endif
            else begin
              res_reg   <= alu_res;
              hi_reg    <= alu_hi;
              zero_reg  <= (alu_res == '0);
              dbz_reg   <= alu_dbz;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end
          end
        end

        MUL: begin
          work_hi_reg <= mul_hi_next;
          work_lo_reg <= mul_lo_next;
          if (cnt_reg == LAST_ITER) begin
            // Final iteration publishes the full product on the same edge.
            res_reg   <= mul_lo_next;
            hi_reg    <= mul_hi_next;
            zero_reg  <= ({mul_hi_next, mul_lo_next} == '0);
            dbz_reg   <= 1'b0;
            done_reg  <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

`ifdef MULTI_CYCLE_ALU_DIV_EN
        DIV: begin
          work_hi_reg <= div_rem_next;
          work_lo_reg <= div_q_next;
          if (cnt_reg == LAST_ITER) begin
            res_reg   <= div_q_next;
            hi_reg    <= div_rem_next;
            zero_reg  <= (div_q_next == '0);
            dbz_reg   <= 1'b0;
            done_reg  <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
`endif

        DONE: begin
          // Always return to IDLE; a start seen here is deliberately dropped.
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.res         = res_reg;
  assign bus.hi          = hi_reg;
  assign bus.zero        = zero_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule
